// File: rtl/aes_ks_pkg.sv
// Shared constants, state encoding and the GF(2^8) doubling helper for the
// AES-128 key-schedule controller.
package aes_ks_pkg;

    localparam int         NR_AES128   = 10;
    localparam logic [7:0] RCON_INIT   = 8'h01;
    localparam logic [7:0] RCON_REDUCE = 8'h1B;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PRESENT,
        WAIT,
        STEP
    } ks_state_e;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_REDUCE : 8'h00);
    endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register: restarts at RCON_INIT on init and doubles in
// GF(2^8) on advance.
module aes_rcon_gen
    import aes_ks_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       init,
    input  logic       advance,
    output logic [7:0] rc
);

    logic [7:0] rc_q;
    logic [7:0] rc_d;

    always_comb begin
        rc_d = rc_q;
        if (init) begin
            rc_d = RCON_INIT;
        end else if (advance) begin
            rc_d = xtime(rc_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rc_q <= RCON_INIT;
        end else begin
            rc_q <= rc_d;
        end
    end

    assign rc = rc_q;

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 round-key expansion sequencer: loads the datapath, paces it around the
// S-box latency and streams round keys 0..NR. Optional store: AES_KS_ROUND_KEY_STORE_EN.
module aes_key_sched_ctrl
    import aes_ks_pkg::*;
#(
    parameter int NR           = NR_AES128,
    parameter int SBOX_LATENCY = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key_in,
    input  logic         abort,
    output logic [127:0] ke_key,
    output logic         ke_load,
    output logic         ke_enable,
    output logic [31:0]  ke_rcon,
    input  logic [127:0] ke_key_out,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_idx,
    output logic         busy,
    output logic         done,
    input  logic [3:0]   rk_rd_idx,
    output logic [127:0] rk_rd_data,
    output logic         store_valid
);

    localparam logic [3:0] NR_IDX    = 4'(NR);
    localparam logic [1:0] WAIT_LOAD = 2'(SBOX_LATENCY);

    ks_state_e    state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic [1:0]   wait_q, wait_d;
    logic [127:0] key_q, key_d;
    logic         rc_init, rc_advance;
    logic [7:0]   rc;
    logic         rk_fire;

    aes_rcon_gen u_rcon (
        .clk    (clk),
        .rst    (rst),
        .init   (rc_init),
        .advance(rc_advance),
        .rc     (rc)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first so that no path
        // through the case statement can leave a signal unassigned and infer a latch.
        state_d    = state_q;
        round_d    = round_q;
        wait_d     = wait_q;
        key_d      = key_q;
        rc_init    = 1'b0;
        rc_advance = 1'b0;
        key_ready  = 1'b0;
        ke_load    = 1'b0;
        ke_enable  = 1'b0;
        ke_rcon    = 32'h0;
        rk_valid   = 1'b0;
        rk_fire    = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            IDLE: begin
                key_ready = !abort;
                if (key_valid && !abort) begin
                    key_d   = key_in;
                    round_d = 4'd0;
                    rc_init = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                ke_load   = 1'b1;
                ke_enable = 1'b1;
                state_d   = PRESENT;
            end
            PRESENT: begin
                rk_valid = 1'b1;
                rk_fire  = rk_ready && !abort;
                if (rk_fire) begin
                    if (round_q == NR_IDX) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end else if (SBOX_LATENCY == 0) begin
                        state_d = STEP;
                    end else begin
                        wait_d  = WAIT_LOAD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wait_q <= 2'd1) begin
                    state_d = STEP;
                end else begin
                    wait_d = wait_q - 2'd1;
                end
            end
            STEP: begin
                ke_enable  = 1'b1;
                ke_rcon    = {rc, 24'h0};
                round_d    = round_q + 4'd1;
                rc_advance = 1'b1;
                state_d    = PRESENT;
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over everything except reset, including a same-cycle handshake.
        if (abort) begin
            state_d    = IDLE;
            key_d      = key_q;
            round_d    = round_q;
            rc_init    = 1'b0;
            rc_advance = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            round_q <= 4'd0;
            wait_q  <= 2'd0;
            key_q   <= 128'h0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            wait_q  <= wait_d;
            key_q   <= key_d;
        end
    end

    // The datapath holds its registers while ke_enable is low, so the stream
    // stays stable under back-pressure without a local copy.
    assign ke_key  = key_q;
    assign rk_data = ke_key_out;
    assign rk_idx  = round_q;
    assign busy    = (state_q != IDLE);

`ifdef AES_KS_ROUND_KEY_STORE_EN
    logic [127:0] store_q [NR+1];
    logic         store_valid_q, store_valid_d;

    always_comb begin
        store_valid_d = store_valid_q;
        if (state_q == LOAD) begin
            store_valid_d = 1'b0;
        end else if (rk_fire && round_q == NR_IDX) begin
            store_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            store_valid_q <= 1'b0;
        end else begin
            store_valid_q <= store_valid_d;
        end
    end

    // NOTE: the key store has no reset; store_valid alone says whether its
    // contents belong to a complete schedule, so resetting the array buys nothing.
    always_ff @(posedge clk) begin
        if (rk_fire && !rst) begin
            store_q[round_q] <= ke_key_out;
        end
    end

    assign rk_rd_data  = (rk_rd_idx <= NR_IDX) ? store_q[rk_rd_idx] : 128'h0;
    assign store_valid = store_valid_q;
`else
    logic unused_rd_idx;
    assign unused_rd_idx = ^rk_rd_idx;
    assign rk_rd_data    = 128'h0;
    assign store_valid   = 1'b0;
`endif

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl: a behavioural AES-128 expansion
// datapath feeds the controller, and round keys are scoreboarded against a reference.
`timescale 1ns/1ps
module tb_aes_key_sched_ctrl;

    localparam int NR = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic [127:0] key_in = '0;
    logic         abort = 1'b0;
    logic [127:0] ke_key;
    logic         ke_load;
    logic         ke_enable;
    logic [31:0]  ke_rcon;
    logic [127:0] ke_key_out;
    logic         rk_valid;
    logic         rk_ready = 1'b0;
    logic [127:0] rk_data;
    logic [3:0]   rk_idx;
    logic         busy;
    logic         done;
    logic [3:0]   rk_rd_idx = '0;
    logic [127:0] rk_rd_data;
    logic         store_valid;

    always #5 clk = ~clk;

    aes_key_sched_ctrl #(.NR(NR), .SBOX_LATENCY(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_in     (key_in),
        .abort      (abort),
        .ke_key     (ke_key),
        .ke_load    (ke_load),
        .ke_enable  (ke_enable),
        .ke_rcon    (ke_rcon),
        .ke_key_out (ke_key_out),
        .rk_valid   (rk_valid),
        .rk_ready   (rk_ready),
        .rk_data    (rk_data),
        .rk_idx     (rk_idx),
        .busy       (busy),
        .done       (done),
        .rk_rd_idx  (rk_rd_idx),
        .rk_rd_data (rk_rd_data),
        .store_valid(store_valid)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // ---------------- AES reference arithmetic ----------------
    logic [7:0] sbox_t [256];
    logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] v);
        logic [7:0] inv;
        inv = 8'h01;
        if (v == 8'h00) inv = 8'h00;
        else for (int i = 0; i < 254; i++) inv = gmul(inv, v);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        logic [31:0] r;
        r = {w[23:0], w[31:24]};
        return {sbox_t[r[31:24]], sbox_t[r[23:16]], sbox_t[r[15:8]], sbox_t[r[7:0]]};
    endfunction

    // s is a key in FIPS string order (first byte in [127:120]); result in rk_data order.
    function automatic logic [127:0] ref_rk(input logic [127:0] s, input int r);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = s[127:96]; w1 = s[95:64]; w2 = s[63:32]; w3 = s[31:0];
        for (int k = 0; k < r; k++) begin
            t  = sub_rot(w3) ^ {rcon_tab[k], 24'h0};
            w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
        end
        return {w3, w2, w1, w0};
    endfunction

    function automatic logic [127:0] words_to_rk(input logic [127:0] s);
        return {s[31:0], s[63:32], s[95:64], s[127:96]};
    endfunction

    function automatic logic [127:0] to_key_in(input logic [127:0] s);
        logic [127:0] k;
        for (int j = 0; j < 16; j++) k[8*j +: 8] = s[127-8*j -: 8];
        return k;
    endfunction

    // ---------------- behavioural datapath, registered S-box (latency 1) ----------------
    logic [31:0] dp_w [4] = '{default: 32'h0};
    logic [31:0] dp_sub_q = 32'h0;
    logic [31:0] dp_t, dp_n0, dp_n1, dp_n2, dp_n3;

    assign dp_t  = dp_sub_q ^ ke_rcon;
    assign dp_n0 = dp_w[0] ^ dp_t;
    assign dp_n1 = dp_w[1] ^ dp_n0;
    assign dp_n2 = dp_w[2] ^ dp_n1;
    assign dp_n3 = dp_w[3] ^ dp_n2;
    assign ke_key_out = {dp_w[3], dp_w[2], dp_w[1], dp_w[0]};

    always @(posedge clk) begin
        dp_sub_q <= sub_rot(dp_w[3]);
        if (ke_enable === 1'b1) begin
            if (ke_load === 1'b1) begin
                for (int i = 0; i < 4; i++)
                    dp_w[i] <= {ke_key[32*i +: 8], ke_key[32*i+8 +: 8],
                                ke_key[32*i+16 +: 8], ke_key[32*i+24 +: 8]};
            end else begin
                dp_w[0] <= dp_n0; dp_w[1] <= dp_n1; dp_w[2] <= dp_n2; dp_w[3] <= dp_n3;
            end
        end
    end

    // ---------------- scoreboard and monitor ----------------
    logic [127:0] sb_data [$];
    logic [3:0]   sb_idx  [$];
    logic [31:0]  rcon_seen [$];
    logic [127:0] got_rk [16];
    int cycle = 0;
    int done_cnt = 0;
    int done_cycle = 0;

    always @(posedge clk) cycle <= cycle + 1;

    always @(posedge clk) begin
        #3;
        if (!rst) begin
            if (rk_valid && rk_ready && !abort) begin
                got_rk[rk_idx] = rk_data;
                check("sb_nonempty", 128'(sb_data.size() > 0), 128'd1);
                if (sb_data.size() > 0) begin
                    check($sformatf("rk_data_r%0d", sb_idx[0]), rk_data, sb_data.pop_front());
                    check("rk_idx", rk_idx, sb_idx.pop_front());
                end
            end
            if (done) begin
                done_cnt++;
                done_cycle = cycle;
            end
            if (ke_enable && !ke_load) rcon_seen.push_back(ke_rcon);
            else check("rcon_zero", ke_rcon, 0);
        end
    end

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    typedef struct {
        logic [127:0] key_s;
        logic [127:0] rk1_s;
        logic [127:0] rk10_s;
    } vec_t;
    vec_t vecs [2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_key(input logic [127:0] s, output int hs);
        bit ok;
        ok = 0;
        hs = -1;
        key_in = to_key_in(s);
        key_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            #2;
            if (key_ready) begin
                ok = 1;
                hs = cycle;
                for (int r = 0; r <= NR; r++) begin
                    sb_data.push_back(ref_rk(s, r));
                    sb_idx.push_back(4'(r));
                end
            end
            tick();
        end
        key_valid = 1'b0;
        check("key_accepted", 128'(ok), 128'd1);
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            #2;
            if (done) seen = 1;
            tick();
        end
    endtask

    task automatic clear_got();
        for (int i = 0; i < 16; i++) got_rk[i] = 'x;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_key_ready"}, key_ready, 1);
        check({tag, "_rk_valid"}, rk_valid, 0);
        check({tag, "_ke_load"}, ke_load, 0);
        check({tag, "_ke_enable"}, ke_enable, 0);
        check({tag, "_ke_rcon"}, ke_rcon, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rk_idx"}, rk_idx, 0);
        check({tag, "_store_valid"}, store_valid, 0);
    endtask

    task automatic run_vec(input int v);
        int hs, lat, d0;
        bit seen;
        rk_ready = 1'b1;
        rcon_seen.delete();
        clear_got();
        d0 = done_cnt;
        send_key(vecs[v].key_s, hs);
        lat = -1;
        for (int i = 0; i < 8 && lat < 0; i++) begin
            #2;
            if (rk_valid) lat = cycle - hs;
            tick();
        end
        check("first_rk_latency", lat, 2);
        wait_done(60, seen);
        check("done_seen", 128'(seen), 1);
        check("done_latency", done_cycle - hs, 32);
        tick();
        check("done_once", done_cnt - d0, 1);
        check("sb_drained", sb_data.size(), 0);
        check("idle_after_done", busy, 0);
        check("rk0_w0", got_rk[0][31:0], vecs[v].key_s[127:96]);
        check("rk1", got_rk[1], words_to_rk(vecs[v].rk1_s));
        check("rk10", got_rk[10], words_to_rk(vecs[v].rk10_s));
        check("rcon_count", rcon_seen.size(), 10);
        for (int i = 0; i < rcon_seen.size() && i < 10; i++)
            check($sformatf("rcon_step%0d", i), rcon_seen[i], {rcon_tab[i], 24'h0});
`ifdef AES_KS_ROUND_KEY_STORE_EN
        rk_rd_idx = 4'd10;
        #2;
        check("store_valid", store_valid, 1);
        check("store_rd10", rk_rd_data, words_to_rk(vecs[v].rk10_s));
        tick();
        rk_rd_idx = 4'd12;
        #2;
        check("store_rd12", rk_rd_data, 0);
        tick();
`else
        rk_rd_idx = 4'd10;
        #2;
        check("store_valid_off", store_valid, 0);
        check("store_rd_off", rk_rd_data, 0);
        tick();
`endif
    endtask

    task automatic run_stall();
        int hs;
        bit hit, seen;
        rk_ready = 1'b1;
        clear_got();
        send_key(vecs[0].key_s, hs);
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (rk_valid && rk_idx == 4'd3) hit = 1;
            else tick();
        end
        check("stall_reached", 128'(hit), 1);
        rk_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #2;
            check("stall_valid", rk_valid, 1);
            check("stall_idx", rk_idx, 3);
            check("stall_data", rk_data, ref_rk(vecs[0].key_s, 3));
            check("stall_ke_enable", ke_enable, 0);
            tick();
        end
        rk_ready = 1'b1;
        wait_done(60, seen);
        check("stall_done", 128'(seen), 1);
        tick();
        check("stall_rk4", got_rk[4], ref_rk(vecs[0].key_s, 4));
    endtask

    task automatic run_abort();
        int hs, d0;
        bit hit;
        rk_ready = 1'b1;
        d0 = done_cnt;
        send_key(vecs[0].key_s, hs);
        hit = 0;
        for (int i = 0; i < 60 && !hit; i++) begin
            if (busy && !rk_valid && !ke_enable && !ke_load && rk_idx == 4'd5) hit = 1;
            else tick();
        end
        check("abort_reached", 128'(hit), 1);
        abort = 1'b1;
        #2;
        check("abort_no_done", done, 0);
        tick();
        abort = 1'b0;
        sb_data.delete();
        sb_idx.delete();
        #2;
        check("abort_busy", busy, 0);
        check("abort_rk_valid", rk_valid, 0);
        check("abort_key_ready", key_ready, 1);
        tick();
        tick();
        check("abort_done_cnt", done_cnt - d0, 0);
        run_vec(1);
    endtask

    task automatic run_busy_reset();
        int hs;
        bit hit;
        rk_ready = 1'b1;
        clear_got();
        send_key(vecs[1].key_s, hs);
        tick();
        key_valid = 1'b1;
        key_in = to_key_in(vecs[0].key_s);
        #2;
        check("busy_key_ready", key_ready, 0);
        check("busy_flag", busy, 1);
        tick();
        key_valid = 1'b0;
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (rk_valid && rk_idx == 4'd2) hit = 1;
            else tick();
        end
        check("rst_reached", 128'(hit), 1);
        rk_ready = 1'b0;
        check("busy_rk1", got_rk[1], words_to_rk(vecs[1].rk1_s));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb_data.delete();
        sb_idx.delete();
        #2;
        check_reset_outputs("midrst");
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{key_s:  128'h2b7e151628aed2a6abf7158809cf4f3c,
                    rk1_s:  128'ha0fafe1788542cb123a339392a6c7605,
                    rk10_s: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[1] = '{key_s:  128'h0,
                    rk1_s:  128'h62636363626363636263636362636363,
                    rk10_s: 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
        for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));

        tick();
        tick();
        rst = 1'b0;
        #2;
        check_reset_outputs("reset");
        tick();

        for (int v = 0; v < 2; v++) run_vec(v);
        run_stall();
        run_abort();
        run_busy_reset();
        run_vec(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_key_sched_ctrl.md
Name: aes_key_sched_ctrl

Overview:
Sequencer for the AES-128 round-key expansion datapath. It accepts a cipher key over a valid/ready handshake and drives the datapath's load enable, register enable and per-round Rcon word. It then waits out the registered S-box latency and presents the round keys 0..NR, one at a time, to the cipher core over a valid/ready stream with back-pressure.

Parameters:
NR, 10, number of rounds; round keys 0..NR are emitted (AES-128 only).
SBOX_LATENCY, 1, clock cycles from a stable W3 to a valid S-box output; legal range 0..3.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
key_valid  in  1  new cipher key offered
key_ready  out  1  controller can accept a key
key_in  in  128  cipher key, first key byte in [7:0]
abort  in  1  synchronous abort of the current schedule
ke_key  out  128  key forwarded to the datapath key input
ke_load  out  1  datapath load_enable
ke_enable  out  1  datapath register enable; registers hold when low
ke_rcon  out  32  Rcon word {rc, 24'h0}
ke_key_out  in  128  datapath key_out {R3,R2,R1,R0}
rk_valid  out  1  round key valid
rk_ready  in  1  cipher core accepts the round key
rk_data  out  128  round key; word w0 in [31:0]
rk_idx  out  4  round index 0..NR
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on acceptance of round key NR
rk_rd_idx  in  4  store read index (optional feature)
rk_rd_data  out  128  store read data (optional feature)
store_valid  out  1  store holds a complete schedule (optional feature)

Behaviour:
- Reset is synchronous and active-high. On reset: state = IDLE, round = 0, rc = 8'h01. Reset values: key_ready = 1, rk_valid = 0, ke_load = 0, ke_enable = 0, ke_rcon = 0, done = 0, busy = 0, rk_idx = 0.
- IDLE: key_ready = 1. On key_valid & key_ready: capture key_in into an internal register, set round = 0, set rc = 8'h01, go to LOAD. key_valid outside IDLE is ignored.
- LOAD (1 cycle): ke_load = 1, ke_enable = 1, ke_key = captured key. Next state: PRESENT.
- PRESENT:
  - Outputs: rk_valid = 1, rk_data = ke_key_out, rk_idx = round. ke_enable = 0.
  - rk_data and rk_idx are stable while rk_valid & !rk_ready.
  - On rk_ready with round == NR: pulse done, go to IDLE.
  - On rk_ready otherwise: go to WAIT and load the wait counter with SBOX_LATENCY. If SBOX_LATENCY == 0, go directly to STEP.
- WAIT: ke_enable = 0. The counter decrements each cycle; at 1, go to STEP.
- STEP (1 cycle): ke_enable = 1, ke_rcon = {rc, 24'h0}. Then round += 1, rc = xtime(rc), where 8'h80 maps to 8'h1B. Next state: PRESENT.
- ke_rcon = 0 in every state except STEP.
- Latency:
  - First rk_valid appears 2 cycles after the key handshake.
  - Each later rk_valid appears SBOX_LATENCY + 2 cycles after the previous rk handshake.
  - With rk_ready tied high and SBOX_LATENCY = 1, done fires 32 cycles after the key handshake.
- abort (any state): go to IDLE next cycle, drop rk_valid, no done pulse. abort has priority over rk_ready in the same cycle. Reset has priority over abort.
- Reset mid-schedule gives the same result as abort, plus all reset values above.
- No new key is accepted until done or abort has returned the block to IDLE.

Optional Feature:
- Macro: AES_KS_ROUND_KEY_STORE_EN.
- Defined:
  - An (NR+1) x 128 register store is written with rk_data at index rk_idx on every rk handshake.
  - rk_rd_data = store[rk_rd_idx] (combinational); rk_rd_idx > NR returns 0.
  - store_valid is cleared in LOAD and set on the round-NR handshake. Reset clears store_valid but not the store contents.
- Not defined: rk_rd_data = 0, store_valid = 0, no storage is inferred.

Decomposition:
- Package aes_ks_pkg: NR_AES128 = 10, RCON_INIT = 8'h01, RCON_REDUCE = 8'h1B, state encoding (IDLE, LOAD, PRESENT, WAIT, STEP), and the xtime function.
- Sub-module aes_rcon_gen: holds rc, with inputs init and advance, output rc.

Test Plan:
- FIPS-197 key 2b7e1516 28aed2a6 abf71588 09cf4f3c, with byte 0x2b in key_in[7:0], rk_ready = 1:
  - rk_idx 0 gives rk_data[31:0] = 2b7e1516.
  - rk_idx 1 gives words a0fafe17 88542cb1 23a33939 2a6c7605 (w0..w3).
  - rk_idx 10 gives words d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
  - done pulses once, 32 cycles after the key handshake.
- ke_rcon across STEP cycles -> sequence 01,02,04,08,10,20,40,80,1B,36 in bits [31:24].
- rk_ready held low 5 cycles at round 3 -> rk_valid, rk_data and rk_idx stay stable, ke_enable = 0, and round 4 data is still correct afterwards.
- abort in WAIT of round 5, then a new key -> no done pulse, and the new schedule starts from round 0 with correct values.
- key_valid pulsed while busy -> ignored, key_ready = 0; rst asserted mid-PRESENT -> all outputs at reset values next cycle.
- With AES_KS_ROUND_KEY_STORE_EN defined, after done -> rk_rd_idx = 10 returns d014f9a8 c9ee2589 e13f0cc8 b6630ca6, store_valid = 1, and rk_rd_idx = 12 returns 0.
